sp_sync_ram_large: RTL and testbench
====================================

# sp_sync_ram_large

Single-port synchronous word-addressed RAM with a shared bidirectional data bus, chip select, write enable and output enable. Wide logical address space (28 bits by default) backed by a smaller banked physical array. Sits behind the processor/memory interconnect as main data/instruction memory; the bus master drives `data` on writes and the RAM drives it on reads.

## Interface
Parameters:
- `ADDR_WIDTH`, 28: logical word-address width.
- `DATA_WIDTH`, 32: word width.
- `BANK_ADDR_WIDTH`, 12: word-address width of one physical bank (4096 words).
- `NUM_BANKS`, 4: number of physical banks; power of two, ≥1.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `addr` input ADDR_WIDTH: word address.
- `data` inout DATA_WIDTH: shared data bus; RAM drives only during reads, high-Z otherwise.
- `cs_input` input 1: chip select, active-high; nothing happens when low.
- `we` input 1: write enable, active-high.
- `oe` input 1: output enable, active-high.

## Operation
- Physical size = NUM_BANKS × 2^BANK_ADDR_WIDTH words. Bank index = `addr[BANK_ADDR_WIDTH +: log2(NUM_BANKS)]`; row = `addr[BANK_ADDR_WIDTH-1:0]`. Remaining upper bits are the "high bits".
- Write: at rising edge with `rst_n`=1, `cs_input`=1, `we`=1 → word at `addr` ← `data`. `oe` ignored during write.
- Read: at rising edge with `cs_input`=1, `we`=0, `oe`=1 → read register ← word at `addr`.
- Bus drive: `data` = read register when `cs_input`=1 && `oe`=1 && `we`=0; else all bits Z.
- `we` has priority over `oe`; RAM never drives the bus while `we`=1.
- Idle (`cs_input`=0, or `we`=0 && `oe`=0): no memory change, read register holds, bus Z.
- Out-of-range (high bits nonzero): behaviour per Configuration.
- Memory contents are not initialised and not cleared by reset; unwritten words read X in simulation.
- Only the selected bank is enabled per access (per-bank enable derived from bank index).

## Timing
- Write latency: word stored at the sampling edge; readable by a read sampled at the next edge.
- Read latency: one cycle — data appears on the bus after the edge that samples the read request, remaining valid while `cs_input`&&`oe`&&!`we` hold and no new read edge occurs.
- Back-to-back reads at successive addresses: one new word per cycle.
- Write then read same address on consecutive edges returns the new value.
- Bus enable is combinational from `cs_input`/`oe`/`we`; turnaround requires no dead cycle from the RAM side.
- Reset: `rst_n` low immediately clears read register to 0; writes are blocked while `rst_n`=0; memory retains contents. A read enabled during reset drives 0. Deassertion is synchronised internally (two-flop) before writes resume.

## Configuration
- `RAM_LARGE_ADDR_WRAP_EN` defined: high bits ignored; out-of-range addresses alias into the physical array (address modulo physical size).
- Not defined: out-of-range writes are dropped; out-of-range reads load 0 into the read register.

## Test plan
- Reset: hold `rst_n`=0 two cycles with `cs_input`=1,`oe`=1,`we`=0 → `data`=0x00000000; `oe`=0 → `data` all Z.
- Write/read sweep: write addr 0..15 with 0x12153524, 0xC0895E81, 0x8484D609, … (one per cycle, `oe`=0), then read 0..15 with `oe`=1 → each value on `data` one cycle after its read edge, in order.
- Bank crossing: write 0xDEADBEEF to addr 0x0FFF and 0xCAFEF00D to 0x1000, read both → values returned distinct and correct.
- Bus control: `cs_input`=0 with `oe`=1 → `data` Z, no write with `we`=1; `we`=1,`oe`=1 → RAM does not drive.
- Out-of-range: write 0xA5A5A5A5 to addr 0x0100_0005 → without macro, read returns 0 and addr 5 unchanged; with macro, addr 5 reads 0xA5A5A5A5.
- Reset mid-read: assert `rst_n`=0 while bus shows 0x8484D609 → `data` becomes 0 immediately; after release, re-read returns 0x8484D609 (contents retained).

Source files
------------

// File: rtl/sp_sync_ram_large.sv
// Single-port synchronous RAM: wide logical word address onto NUM_BANKS banks of
// 2**BANK_ADDR_WIDTH words, shared tri-state data bus. Option macro: RAM_LARGE_ADDR_WRAP_EN.
module sp_sync_ram_large #(
  parameter int ADDR_WIDTH      = 28,
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int NUM_BANKS       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe
);

  localparam int BANK_SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PHYS_W     = BANK_ADDR_WIDTH + $clog2(NUM_BANKS);
  localparam int ROWS       = 1 << BANK_ADDR_WIDTH;

  // Reset assertion is immediate; deassertion is retimed so writes resume cleanly.
  logic [1:0] rst_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  logic                       wr_ok;
  logic                       in_range;
  logic                       rd_fire;
  logic [BANK_ADDR_WIDTH-1:0] row;
  logic [BANK_SEL_W-1:0]      bank_idx;
  logic [NUM_BANKS-1:0]       bank_en;
  logic [DATA_WIDTH-1:0]      bank_word [NUM_BANKS];
  logic [DATA_WIDTH-1:0]      rd_q;

  assign wr_ok   = rst_sync[1];
  assign row     = addr[BANK_ADDR_WIDTH-1:0];
  assign rd_fire = cs_input && oe && !we;

`ifdef RAM_LARGE_ADDR_WRAP_EN
  // High address bits alias into the physical array.
  assign in_range = 1'b1;
  wire unused_high_bits = ^addr[ADDR_WIDTH-1:PHYS_W];
`else
  assign in_range = (addr[ADDR_WIDTH-1:PHYS_W] == '0);
`endif

  if (NUM_BANKS > 1) begin : g_multi_bank
    assign bank_idx = addr[BANK_ADDR_WIDTH +: BANK_SEL_W];
  end else begin : g_single_bank
    assign bank_idx = '0;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];

    assign bank_en[b] = cs_input && in_range && (bank_idx == BANK_SEL_W'(b));

    // Contents are never reset; only the addressed bank sees a write strobe.
    always_ff @(posedge clk) begin
      if (bank_en[b] && we && wr_ok) mem[row] <= data;
    end

    assign bank_word[b] = mem[row];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_fire) begin
      rd_q <= in_range ? bank_word[bank_idx] : '0;
    end
  end

  // Bus protocol: the RAM drives data only while cs_input && oe && !we; the master
  // owns the bus whenever we is high, so direction turnaround needs no dead cycle.
  assign data = rd_fire ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_sync_ram_large.sv
// Randomised self-checking bench for sp_sync_ram_large against an associative-array memory model.
module tb_sp_sync_ram_large;

  localparam int AW    = 28;
  localparam int DW    = 32;
  localparam int PHYS  = 4 * 4096;
  localparam logic [DW-1:0] FLOAT = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          cs_input;
  logic          we;
  logic          oe;
  logic          tb_en;
  logic [DW-1:0] tb_drive;
  wire  [DW-1:0] data;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [int];

  // Undriven bus floats high so a released bus is observable.
  for (genvar i = 0; i < DW; i++) begin : g_pu
    pullup (data[i]);
  end
  assign data = tb_en ? tb_drive : {DW{1'bz}};

  sp_sync_ram_large dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data     (data),
    .cs_input (cs_input),
    .we       (we),
    .oe       (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_oor(input logic [AW-1:0] a);
    return int'(a) >= PHYS;
  endfunction

  function automatic void m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef RAM_LARGE_ADDR_WRAP_EN
    m_mem[int'(a) % PHYS] = d;
`else
    if (!m_oor(a)) m_mem[int'(a)] = d;
`endif
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, output bit known);
    int k;
`ifdef RAM_LARGE_ADDR_WRAP_EN
    k = int'(a) % PHYS;
`else
    if (m_oor(a)) begin
      known = 1'b1;
      return '0;
    end
    k = int'(a);
`endif
    known = m_mem.exists(k);
    return known ? m_mem[k] : '0;
  endfunction

  // All driver tasks start and end on a falling edge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; cs_input = 1'b1; we = 1'b1; oe = 1'b0;
    tb_drive = d; tb_en = 1'b1;
    @(negedge clk);
    m_write(a, d);
    tb_en = 1'b0; we = 1'b0; cs_input = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag);
    logic [DW-1:0] exp;
    bit known;
    addr = a; cs_input = 1'b1; we = 1'b0; oe = 1'b1; tb_en = 1'b0;
    @(negedge clk);
    exp = m_read(a, known);
    if (known) check(tag, data, exp);
  endtask

  task automatic idle(input int n);
    cs_input = 1'b0; we = 1'b0; oe = 1'b0; tb_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [DW-1:0] sweep [16];

  initial begin
    rst_n = 1'b0; addr = '0; cs_input = 1'b1; we = 1'b0; oe = 1'b1;
    tb_en = 1'b0; tb_drive = '0;

    // Reset drives zero on an enabled read, releases the bus otherwise.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_zero", data, '0);
    oe = 1'b0;
    #1 check("rst_bus_z", data, FLOAT);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Write/read sweep, reads back-to-back.
    sweep[0] = 32'h1215_3524; sweep[1] = 32'hC089_5E81; sweep[2] = 32'h8484_D609;
    for (int i = 3; i < 16; i++) sweep[i] = $urandom;
    for (int i = 0; i < 16; i++) wr(AW'(i), sweep[i]);
    for (int i = 0; i < 16; i++) rd(AW'(i), $sformatf("sweep_%0d", i));
    idle(1);

    // Bank crossing and read-register hold while deselected.
    wr(28'h0FFF, 32'hDEAD_BEEF);
    wr(28'h1000, 32'hCAFE_F00D);
    rd(28'h0FFF, "bank_lo");
    idle(1);
    addr = 28'h1000; cs_input = 1'b1; oe = 1'b1;
    #1 check("rd_hold", data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("bank_hi", data, 32'hCAFE_F00D);

    // Deselected: no drive, no write.
    cs_input = 1'b0; oe = 1'b1; we = 1'b0;
    #1 check("cs_low_z", data, FLOAT);
    addr = 28'h0; we = 1'b1; tb_drive = 32'h1111_1111; tb_en = 1'b1;
    @(negedge clk);
    idle(1);
    rd(28'h0, "cs_low_nowrite");

    // we overrides oe: RAM must release the bus (the floating value is what lands).
    addr = 28'h20; cs_input = 1'b1; we = 1'b1; oe = 1'b1; tb_en = 1'b0;
    #1 check("we_oe_no_drive", data, FLOAT);
    @(negedge clk);
    m_write(28'h20, FLOAT);
    idle(1);
    rd(28'h20, "we_oe_readback");

    // Out-of-range access.
    wr(28'h0100_0005, 32'hA5A5_A5A5);
    rd(28'h0100_0005, "oor_read");
    rd(28'h5, "oor_alias_addr5");
    idle(1);

    // Reset while a read is on the bus; writes blocked during reset.
    rd(28'h2, "pre_rst_rd");
    #1 rst_n = 1'b0;
    #1 check("rst_mid_read", data, '0);
    @(negedge clk);
    addr = 28'h3; cs_input = 1'b1; we = 1'b1; oe = 1'b0;
    tb_drive = 32'h0BAD_0BAD; tb_en = 1'b1;
    @(negedge clk);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    rd(28'h2, "post_rst_rd2");
    rd(28'h3, "rst_blocks_wr");
    idle(1);

    // Random traffic around bank edges and out-of-range aliases.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a;
      int op;
      case ($urandom_range(0, 3))
        0: a = AW'($urandom_range(0, 3) * 4096);
        1: a = AW'($urandom_range(0, 3) * 4096 + 4095);
        default: a = AW'($urandom_range(0, 3) * 4096 + $urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 7) == 0) a[$urandom_range(14, AW-1)] = 1'b1;
      op = $urandom_range(0, 9);
      if (op < 5)      wr(a, $urandom);
      else if (op < 9) rd(a, "rand_rd");
      else             idle(1);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
